// File: rtl/sevenseg_pkg.sv
// Shared types, segment constants and the BCD-to-7-segment decoder
// for the scanned display counter.
package sevenseg_pkg;

    typedef logic [3:0] bcd_t;

    // Segment patterns, active-high, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Codes 10..15 cannot come out of the counter; they blank the digit
    function automatic logic [6:0] seg_decode(input bcd_t d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/sevenseg_scan_counter_if.sv
// Control and display bundle of the scanned BCD counter.
// master: user-input side (drives inc/clr, observes display); slave: the counter.
interface sevenseg_scan_counter_if #(
    parameter int N_DIGITS = 2
) ();
    logic                    inc;
    logic                    clr;
    logic [6:0]              seg;
    logic                    dp;
    logic [N_DIGITS-1:0]     dig_sel;
    logic [4*N_DIGITS-1:0]   count_bcd;
    logic                    wrap;

    modport master (
        output inc, clr,
        input  seg, dp, dig_sel, count_bcd, wrap
    );

    modport slave (
        input  inc, clr,
        output seg, dp, dig_sel, count_bcd, wrap
    );
endinterface

// File: rtl/sevenseg_scan_counter_bcd_digit.sv
// One decade of the BCD ripple counter. carry is combinational so a
// whole chain of 9s rolls over in a single cycle.
import sevenseg_pkg::*;

module bcd_digit (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output bcd_t digit,
    output logic carry
);
    bcd_t digit_reg;

    // Decade count 0..9; clear wins over enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            digit_reg <= '0;
        else if (clr)
            digit_reg <= '0;
        else if (en)
            digit_reg <= (digit_reg == 4'd9) ? 4'd0 : digit_reg + 4'd1;
    end

    assign digit = digit_reg;
    assign carry = en && (digit_reg == 4'd9);
endmodule

// File: rtl/sevenseg_scan_counter.sv
// N-digit BCD up-counter with time-multiplexed 7-segment output.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zeros,
// the ones digit always shows).
import sevenseg_pkg::*;

module sevenseg_scan_counter #(
    parameter int N_DIGITS       = 2,
    parameter int REFRESH_DIV    = 4,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    sevenseg_scan_counter_if.slave bus
);
    localparam int   IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int   REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic POL   = (SEG_ACTIVE_LOW != 0);

    logic [REF_W-1:0]      refresh_cnt_reg;
    logic [IDX_W-1:0]      scan_idx_reg;
    logic                  tick;
    bcd_t                  digit_val [N_DIGITS];
    logic [N_DIGITS:0]     en_chain;
    logic [6:0]            seg_reg, seg_next;
    logic                  dp_reg, dp_next;
    logic [N_DIGITS-1:0]   dig_sel_reg, dig_sel_next;
    logic                  wrap_reg, wrap_next;
    bcd_t                  cur_digit;

    assign tick = (refresh_cnt_reg == REF_W'(REFRESH_DIV - 1));

    // Refresh divider: 0..REFRESH_DIV-1, restarting on tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            refresh_cnt_reg <= '0;
        else if (tick)
            refresh_cnt_reg <= '0;
        else
            refresh_cnt_reg <= refresh_cnt_reg + 1'b1;
    end

    // Scan index steps through the digits once per refresh slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            scan_idx_reg <= '0;
        else if (tick)
            scan_idx_reg <= (scan_idx_reg == IDX_W'(N_DIGITS - 1)) ? '0 : scan_idx_reg + 1'b1;
    end

    // Ripple chain: each digit's carry enables the next one up
    assign en_chain[0] = bus.inc;
    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            bcd_digit u_digit (
                .clk   (clk),
                .reset (reset),
                .en    (en_chain[gi]),
                .clr   (bus.clr),
                .digit (digit_val[gi]),
                .carry (en_chain[gi+1])
            );
            assign bus.count_bcd[4*gi +: 4] = digit_val[gi];
        end
    endgenerate

    assign wrap_next = en_chain[N_DIGITS] && !bus.clr;

`ifdef LEADING_ZERO_BLANK_EN
    // lz_chain[i]: digit i and every digit above it are zero
    logic [N_DIGITS:0] lz_chain;
    logic              cur_lz;
    assign lz_chain[N_DIGITS] = 1'b1;
    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_lz
            assign lz_chain[gi] = lz_chain[gi+1] && (digit_val[gi] == 4'd0);
        end
    endgenerate
`endif

    // Pick the digit under scan and build the active-high display word
    always_comb begin
        cur_digit = '0;
`ifdef LEADING_ZERO_BLANK_EN
        cur_lz = 1'b0;
`endif
        for (int i = 0; i < N_DIGITS; i++) begin
            if (scan_idx_reg == IDX_W'(i)) begin
                cur_digit = digit_val[i];
`ifdef LEADING_ZERO_BLANK_EN
                cur_lz = lz_chain[i];
`endif
            end
        end
        seg_next = seg_decode(cur_digit);
`ifdef LEADING_ZERO_BLANK_EN
        if (cur_lz && (scan_idx_reg != '0))
            seg_next = SEG_BLANK;
`endif
        dig_sel_next = N_DIGITS'(1) << scan_idx_reg;
        dp_next      = (scan_idx_reg == IDX_W'(N_DIGITS - 1));
    end

    // Output registers; polarity applied here so reset shows "all off"
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_reg     <= {7{POL}};
            dp_reg      <= POL;
            dig_sel_reg <= {N_DIGITS{POL}};
            wrap_reg    <= 1'b0;
        end else begin
            seg_reg     <= seg_next ^ {7{POL}};
            dp_reg      <= dp_next ^ POL;
            dig_sel_reg <= dig_sel_next ^ {N_DIGITS{POL}};
            wrap_reg    <= wrap_next;
        end
    end

    assign bus.seg     = seg_reg;
    assign bus.dp      = dp_reg;
    assign bus.dig_sel = dig_sel_reg;
    assign bus.wrap    = wrap_reg;
endmodule
